// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: issues one start pulse per decoded mul/div, stalls until ready or timeout, then writes back once.
module multdiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7,
  parameter int RSTATUS_REG    = 30,
  parameter int MUL_EXC_CODE   = 4,
  parameter int DIV_EXC_CODE   = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] dx_insn,
  input  logic        dx_valid,
  input  logic [31:0] dx_opA,
  input  logic [31:0] dx_opB,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        md_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        timeout_err
);
  localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_rd;
  logic             r_div, r_exc, r_tmo;
  logic [31:0]      r_opa, r_opb, r_res;
  logic             w_hit, w_busy, w_done, w_unused;
  assign w_hit    = dx_valid && dx_insn[31:27] == 5'd0 && dx_insn[6:3] == 4'b0011;
  assign w_busy   = r_state == S_BUSY;
  assign w_done   = r_state == S_DONE;
  assign w_unused = ^{dx_insn[21:7], dx_insn[1:0]};
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_div   <= 1'b0;
      r_exc   <= 1'b0;
      r_tmo   <= 1'b0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
    end else begin
      r_tmo <= 1'b0;
      case (r_state)
        S_IDLE: if (w_hit) begin
          r_state <= S_BUSY;
          r_cnt   <= '0;
          r_opa   <= dx_opA;
          r_opb   <= dx_opB;
          r_rd    <= dx_insn[26:22];
          r_div   <= dx_insn[2];
        end
        S_BUSY: if (md_ready) begin
          r_state <= S_DONE;
          r_res   <= md_result;
          r_exc   <= md_exception;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          r_state <= S_IDLE;
          r_tmo   <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  // start pulse only on the first BUSY cycle, selected by the latched opcode
  assign md_ctrl_mult = w_busy && r_cnt == '0 && !r_div;
  assign md_ctrl_div  = w_busy && r_cnt == '0 && r_div;
  assign md_opA       = r_opa;
  assign md_opB       = r_opb;
  assign md_stall     = reset_n && (w_busy || (r_state == S_IDLE && w_hit));
  assign wb_valid     = w_done && (r_exc || r_rd != 5'd0);
  assign wb_rd        = !w_done ? 5'd0 : r_exc ? 5'(RSTATUS_REG) : r_rd;
  assign wb_data      = !w_done ? 32'd0 : !r_exc ? r_res : r_div ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
  assign timeout_err  = r_tmo;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: directed scenarios for the mul/div sequencer with hand-computed expectations.
module tb_multdiv_sequencer;
  logic        clock = 1'b0, reset_n = 1'b0;
  logic [31:0] dx_insn = '0, dx_opA = '0, dx_opB = '0, md_result = '0;
  logic        dx_valid = 1'b0, md_ready = 1'b0, md_exception = 1'b0;
  logic        md_ctrl_mult, md_ctrl_div, md_stall, wb_valid, timeout_err;
  logic [31:0] md_opA, md_opB, wb_data;
  logic [4:0]  wb_rd;
  int total = 0, bad = 0;
  int n_mul, n_div, n_stall, n_wb, n_tmo, wb_k, tmo_k;
  logic [4:0]  last_rd;
  logic [31:0] last_data, opa_seen, opb_seen;

  multdiv_sequencer dut (
    .clock(clock), .reset_n(reset_n), .dx_insn(dx_insn), .dx_valid(dx_valid),
    .dx_opA(dx_opA), .dx_opB(dx_opB), .md_ready(md_ready), .md_exception(md_exception),
    .md_result(md_result), .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_opA(md_opA), .md_opB(md_opB), .md_stall(md_stall), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] alu);
    return {op, rd, 5'd1, 5'd2, 5'd0, alu, 2'b00};
  endfunction

  task automatic observe(input int k);
    if (md_ctrl_mult) begin n_mul++; opa_seen = md_opA; opb_seen = md_opB; end
    if (md_ctrl_div) n_div++;
    if (md_stall) n_stall++;
    if (wb_valid) begin n_wb++; last_rd = wb_rd; last_data = wb_data; wb_k = k; end
    if (timeout_err) begin n_tmo++; tmo_k = k; end
  endtask

  // cycle 0 presents the instruction; later cycles scramble DX operands and pulse md_ready at ready_at
  task automatic do_op(input logic [31:0] insn, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input int ready_at, input logic exc, input logic [31:0] res, input int ncyc);
    n_mul = 0; n_div = 0; n_stall = 0; n_wb = 0; n_tmo = 0; wb_k = -1; tmo_k = -1;
    last_rd = '0; last_data = '0; opa_seen = '0; opb_seen = '0;
    @(negedge clock);
    dx_insn = insn; dx_valid = v; dx_opA = a; dx_opB = b; md_ready = 1'b0; md_exception = 1'b0;
    #1 observe(0);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clock);
      dx_valid = 1'b0; dx_opA = 32'hdead0000 + k; dx_opB = ~a;
      md_ready = (k == ready_at); md_exception = exc && (k == ready_at);
      md_result = (k == ready_at) ? res : 32'h0bad0bad;
      #1 observe(k);
    end
    @(negedge clock);
    md_ready = 1'b0; md_exception = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; dx_insn = mk(5'd0, 5'd3, 5'd6); dx_valid = 1'b1; dx_opA = 32'd6; dx_opB = 32'd7;
    #2;
    total++; if ({md_ctrl_mult, md_ctrl_div, md_stall, wb_valid, timeout_err} !== 5'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=00000", {md_ctrl_mult, md_ctrl_div, md_stall, wb_valid, timeout_err}); end
    total++; if ({md_opA, md_opB, wb_data, wb_rd} !== '0) begin bad++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", md_opA, md_opB, wb_data, wb_rd); end
    dx_valid = 1'b0;
    @(negedge clock); reset_n = 1'b1;
  endtask

  task automatic test_mul;
    do_op(mk(5'd0, 5'd3, 5'd6), 1'b1, 32'd6, 32'd7, 4, 1'b0, 32'd42, 5);
    total++; if (n_mul !== 1 || n_div !== 0) begin bad++; $display("FAIL mul_pulses got=%0d/%0d exp=1/0", n_mul, n_div); end
    total++; if (opa_seen !== 32'd6 || opb_seen !== 32'd7) begin bad++; $display("FAIL mul_ops got=%0d/%0d exp=6/7", opa_seen, opb_seen); end
    total++; if (n_stall !== 5) begin bad++; $display("FAIL mul_stall got=%0d exp=5", n_stall); end
    total++; if (n_wb !== 1 || wb_k !== 5) begin bad++; $display("FAIL mul_wb got=%0d@%0d exp=1@5", n_wb, wb_k); end
    total++; if (last_rd !== 5'd3 || last_data !== 32'd42) begin bad++; $display("FAIL mul_wbval got=%0d/%0d exp=3/42", last_rd, last_data); end
    total++; if (md_opA !== 32'd6) begin bad++; $display("FAIL mul_hold got=%0d exp=6", md_opA); end
  endtask

  task automatic test_exception;
    do_op(mk(5'd0, 5'd4, 5'd7), 1'b1, 32'd10, 32'd0, 2, 1'b1, 32'd0, 3);
    total++; if (n_div !== 1 || n_mul !== 0) begin bad++; $display("FAIL div_pulses got=%0d/%0d exp=1/0", n_div, n_mul); end
    total++; if (n_wb !== 1 || last_rd !== 5'd30 || last_data !== 32'd5) begin bad++; $display("FAIL div_exc got=%0d rd=%0d data=%0d exp=1 rd=30 data=5", n_wb, last_rd, last_data); end
    do_op(mk(5'd0, 5'd5, 5'd6), 1'b1, 32'h7fffffff, 32'd2, 1, 1'b1, 32'd0, 2);
    total++; if (n_wb !== 1 || last_rd !== 5'd30 || last_data !== 32'd4) begin bad++; $display("FAIL mul_exc got=%0d rd=%0d data=%0d exp=1 rd=30 data=4", n_wb, last_rd, last_data); end
    total++; if (wb_k !== 2) begin bad++; $display("FAIL ready_first_busy got=%0d exp=2", wb_k); end
  endtask

  task automatic test_timeout;
    do_op(mk(5'd0, 5'd6, 5'd6), 1'b1, 32'd1, 32'd1, 0, 1'b0, 32'd0, 68);
    total++; if (n_tmo !== 1 || tmo_k !== 65) begin bad++; $display("FAIL tmo_pulse got=%0d@%0d exp=1@65", n_tmo, tmo_k); end
    total++; if (n_stall !== 65) begin bad++; $display("FAIL tmo_stall got=%0d exp=65", n_stall); end
    total++; if (n_wb !== 0 || n_mul !== 1) begin bad++; $display("FAIL tmo_wb got=%0d mul=%0d exp=0 mul=1", n_wb, n_mul); end
  endtask

  task automatic test_back_to_back;
    do_op(mk(5'd0, 5'd7, 5'd6), 1'b1, 32'd3, 32'd5, 2, 1'b0, 32'd15, 3);
    total++; if (n_mul !== 1 || n_div !== 0 || n_wb !== 1 || last_rd !== 5'd7 || last_data !== 32'd15) begin bad++; $display("FAIL b2b_first got=m%0d d%0d w%0d rd=%0d data=%0d exp=m1 d0 w1 rd=7 data=15", n_mul, n_div, n_wb, last_rd, last_data); end
    do_op(mk(5'd0, 5'd8, 5'd7), 1'b1, 32'd20, 32'd4, 3, 1'b0, 32'd5, 4);
    total++; if (n_mul !== 0 || n_div !== 1 || n_wb !== 1 || last_rd !== 5'd8 || last_data !== 32'd5) begin bad++; $display("FAIL b2b_second got=m%0d d%0d w%0d rd=%0d data=%0d exp=m0 d1 w1 rd=8 data=5", n_mul, n_div, n_wb, last_rd, last_data); end
    total++; if (n_stall !== 4 || wb_k !== 4) begin bad++; $display("FAIL b2b_timing got=stall%0d wb@%0d exp=stall4 wb@4", n_stall, wb_k); end
  endtask

  task automatic test_reset_mid;
    do_op(mk(5'd0, 5'd9, 5'd6), 1'b1, 32'd2, 32'd3, 0, 1'b0, 32'd0, 2);
    reset_n = 1'b0; dx_insn = mk(5'd0, 5'd9, 5'd6); dx_valid = 1'b1;
    #1;
    total++; if ({md_ctrl_mult, md_ctrl_div, md_stall, wb_valid, timeout_err} !== 5'b0 || md_opA !== '0 || md_opB !== '0) begin bad++; $display("FAIL rst_mid got=%b opA=%0d exp=00000 opA=0", {md_ctrl_mult, md_ctrl_div, md_stall, wb_valid, timeout_err}, md_opA); end
    @(negedge clock); dx_valid = 1'b0; reset_n = 1'b1;
    do_op(mk(5'd0, 5'd9, 5'd6), 1'b0, 32'd2, 32'd3, 1, 1'b0, 32'd99, 4);
    total++; if (n_wb !== 0 || n_mul !== 0 || n_stall !== 0) begin bad++; $display("FAIL rst_after got=w%0d m%0d s%0d exp=w0 m0 s0", n_wb, n_mul, n_stall); end
  endtask

  task automatic test_nohit;
    do_op(mk(5'd0, 5'd0, 5'd6), 1'b1, 32'd4, 32'd4, 2, 1'b0, 32'd16, 3);
    total++; if (n_mul !== 1 || n_wb !== 0) begin bad++; $display("FAIL rd0 got=m%0d w%0d exp=m1 w0", n_mul, n_wb); end
    do_op(mk(5'd0, 5'd3, 5'd0), 1'b1, 32'd1, 32'd1, 0, 1'b0, 32'd0, 2);
    total++; if (n_stall !== 0 || n_mul + n_div !== 0) begin bad++; $display("FAIL add got=s%0d p%0d exp=s0 p0", n_stall, n_mul + n_div); end
    do_op(mk(5'b01000, 5'd3, 5'd6), 1'b1, 32'd1, 32'd1, 0, 1'b0, 32'd0, 2);
    total++; if (n_stall !== 0 || n_mul + n_div !== 0) begin bad++; $display("FAIL lw got=s%0d p%0d exp=s0 p0", n_stall, n_mul + n_div); end
    do_op(mk(5'd0, 5'd3, 5'd7), 1'b0, 32'd1, 32'd1, 1, 1'b0, 32'd7, 2);
    total++; if (n_stall !== 0 || n_mul + n_div !== 0 || n_wb !== 0) begin bad++; $display("FAIL bubble got=s%0d p%0d w%0d exp=s0 p0 w0", n_stall, n_mul + n_div, n_wb); end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_exception;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    test_nohit;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
